// File: rtl/rp_ioctl_pkg.sv
// Shared definitions for the hps_io ioctl transfer paths (ROM download, hiscore upload).
package rp_ioctl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PAUSE,
    READY,
    FETCH
  } upl_state_t;

  localparam logic [7:0] IDX_ROM     = 8'd0;
  localparam logic [7:0] IDX_HISCORE = 8'd4;

  // Returned for addresses beyond the RAM window so the host still gets a byte.
  localparam logic [7:0] OOW_BYTE    = 8'hFF;

endpackage

// File: rtl/upload_lat_pipe.sv
// RAM_LAT-deep valid shift register: flags the cycle in which RAM read data is valid.
module upload_lat_pipe #(
  parameter int LAT = 1
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic start,
  input  logic kill,
  output logic capture
);

  logic [LAT-1:0] stages;

  // kill flushes every fetch in flight, including one entering this cycle.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      stages <= '0;
    end else if (kill) begin
      stages <= '0;
    end else begin
      stages[0] <= start;
      for (int i = 1; i < LAT; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign capture = stages[LAT-1];

endmodule

// File: rtl/hiscore_upload_server.sv
// Streams hiscore/NVRAM bytes from CPU work RAM to the HPS over the ioctl upload path,
// holding the core paused for the whole session so the image is coherent.
module hiscore_upload_server
  import rp_ioctl_pkg::*;
#(
  parameter logic [7:0] UPLOAD_INDEX = IDX_HISCORE,
  parameter int         ADDR_W       = 10,
  parameter int         RAM_LAT      = 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              pause_req,
  input  logic              pause_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_q,
  output logic              busy,
  output logic [7:0]        checksum,
  output logic              done
);

  upl_state_t state;
  logic       upload_q;
  logic       issue;
  logic       oow_q;
  logic       capture;
  logic       upload_rise;
  logic       session_end;
  logic       addr_oow;
  logic [7:0] fetched;

  assign upload_rise = ioctl_upload & ~upload_q;
  assign session_end = ~ioctl_upload & upload_q & (state != IDLE);
  assign addr_oow    = |ioctl_addr[24:ADDR_W];
  assign fetched     = oow_q ? OOW_BYTE : ram_q;

  upload_lat_pipe #(
    .LAT (RAM_LAT)
  ) u_lat_pipe (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .start   (issue),
    .kill    (session_end),
    .capture (capture)
  );

  // Session end overrides everything; an in-flight fetch is dropped via the pipe kill.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      upload_q   <= 1'b0;
      issue      <= 1'b0;
      oow_q      <= 1'b0;
      ioctl_din  <= '0;
      ioctl_wait <= 1'b0;
      pause_req  <= 1'b0;
      ram_addr   <= '0;
      ram_rd     <= 1'b0;
      busy       <= 1'b0;
      checksum   <= '0;
      done       <= 1'b0;
    end else begin
      upload_q <= ioctl_upload;
      ram_rd   <= 1'b0;
      issue    <= 1'b0;
      done     <= 1'b0;
      if (session_end) begin
        state      <= IDLE;
        pause_req  <= 1'b0;
        ioctl_wait <= 1'b0;
        busy       <= 1'b0;
        done       <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (upload_rise && ioctl_index == UPLOAD_INDEX) begin
              state      <= PAUSE;
              pause_req  <= 1'b1;
              ioctl_wait <= 1'b1;
              busy       <= 1'b1;
              checksum   <= '0;
            end
          end
          PAUSE: begin
            if (pause_ack) begin
              state      <= READY;
              ioctl_wait <= 1'b0;
            end
          end
          READY: begin
            // Out-of-window reads never touch the RAM but keep the same timing.
            if (ioctl_rd) begin
              state      <= FETCH;
              ioctl_wait <= 1'b1;
              issue      <= 1'b1;
              oow_q      <= addr_oow;
              if (!addr_oow) begin
                ram_rd   <= 1'b1;
                ram_addr <= ioctl_addr[ADDR_W-1:0];
              end
            end
          end
          FETCH: begin
            if (capture) begin
              state      <= READY;
              ioctl_din  <= fetched;
              checksum   <= checksum + fetched;
              ioctl_wait <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hiscore_upload_server.sv
// Randomized self-checking bench for hiscore_upload_server against a byte-level reference model.
module tb_hiscore_upload_server;

  localparam int ADDR_W  = 10;
  localparam int RAM_LAT = 2;

  logic              clk_sys;
  logic              reset_n;
  logic              ioctl_upload;
  logic [7:0]        ioctl_index;
  logic              ioctl_rd;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_din;
  logic              ioctl_wait;
  logic              pause_req;
  logic              pause_ack;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd;
  logic [7:0]        ram_q;
  logic              busy;
  logic [7:0]        checksum;
  logic              done;

  logic [7:0] mem [0:(1<<ADDR_W)-1];
  logic [7:0] ram_stage;
  logic [7:0] exp_sum;
  logic [7:0] exp_din;
  int         check_count;
  int         pass_count;

  hiscore_upload_server #(
    .UPLOAD_INDEX (8'd4),
    .ADDR_W       (ADDR_W),
    .RAM_LAT      (RAM_LAT)
  ) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .ioctl_upload (ioctl_upload),
    .ioctl_index  (ioctl_index),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .ioctl_wait   (ioctl_wait),
    .pause_req    (pause_req),
    .pause_ack    (pause_ack),
    .ram_addr     (ram_addr),
    .ram_rd       (ram_rd),
    .ram_q        (ram_q),
    .busy         (busy),
    .checksum     (checksum),
    .done         (done)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Two-cycle RAM; data is garbage outside the valid cycle so mistimed captures show up.
  always @(posedge clk_sys) begin
    ram_stage <= ram_rd ? mem[ram_addr] : 8'($urandom);
    ram_q     <= ram_stage;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    else
      pass_count++;
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic open_session(input int ack_delay);
    ioctl_index  = 8'd4;
    ioctl_upload = 1'b1;
    step();
    checkOutput("start_pause_req", pause_req, 1);
    checkOutput("start_busy", busy, 1);
    checkOutput("start_checksum", checksum, 0);
    for (int i = 0; i < ack_delay; i++) begin
      checkOutput("pause_wait", ioctl_wait, 1);
      if (i < ack_delay - 1) step();
    end
    pause_ack = 1'b1;
    step();
    checkOutput("ready_wait", ioctl_wait, 0);
    checkOutput("ready_pause_req", pause_req, 1);
    exp_sum = 8'h00;
  endtask

  task automatic close_session();
    ioctl_upload = 1'b0;
    pause_ack    = 1'b0;
    step();
    checkOutput("end_done", done, 1);
    checkOutput("end_pause_req", pause_req, 0);
    checkOutput("end_busy", busy, 0);
    checkOutput("end_wait", ioctl_wait, 0);
    checkOutput("end_checksum", checksum, exp_sum);
    step();
    checkOutput("done_one_cycle", done, 0);
    checkOutput("checksum_hold", checksum, exp_sum);
  endtask

  task automatic applyStimulus(input logic [24:0] addr, input bit poke);
    logic       in_win;
    logic [7:0] exp_byte;
    in_win   = (addr < 25'(1 << ADDR_W));
    exp_byte = in_win ? mem[addr[ADDR_W-1:0]] : 8'hFF;
    ioctl_addr = addr;
    ioctl_rd   = 1'b1;
    step();
    ioctl_rd = 1'b0;
    checkOutput("ram_rd_issue", ram_rd, in_win);
    checkOutput("fetch_wait", ioctl_wait, 1);
    if (in_win) checkOutput("ram_addr", ram_addr, addr[ADDR_W-1:0]);
    if (poke) begin
      ioctl_rd   = 1'b1;
      ioctl_addr = 25'($urandom_range(0, (1 << ADDR_W) - 1));
    end
    step();
    ioctl_rd = 1'b0;
    checkOutput("no_extra_rd", ram_rd, 0);
    step();
    checkOutput("wait_in_flight", ioctl_wait, 1);
    checkOutput("no_rd_in_flight", ram_rd, 0);
    step();
    exp_sum = exp_sum + exp_byte;
    exp_din = exp_byte;
    checkOutput("din", ioctl_din, exp_byte);
    checkOutput("wait_released", ioctl_wait, 0);
    checkOutput("checksum", checksum, exp_sum);
  endtask

  function automatic logic [24:0] rand_addr();
    if ($urandom_range(0, 3) == 0)
      return 25'($urandom_range(1 << ADDR_W, (1 << 25) - 1));
    return 25'($urandom_range(0, (1 << ADDR_W) - 1));
  endfunction

  initial begin
    check_count  = 0;
    pass_count   = 0;
    exp_sum      = 8'h00;
    exp_din      = 8'h00;
    reset_n      = 1'b0;
    ioctl_upload = 1'b0;
    ioctl_index  = 8'd0;
    ioctl_rd     = 1'b0;
    ioctl_addr   = '0;
    pause_ack    = 1'b0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'($urandom);
    repeat (3) step();
    checkOutput("rst_din", ioctl_din, 0);
    checkOutput("rst_wait", ioctl_wait, 0);
    checkOutput("rst_pause_req", pause_req, 0);
    checkOutput("rst_ram_rd", ram_rd, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_checksum", checksum, 0);
    checkOutput("rst_done", done, 0);
    reset_n = 1'b1;
    step();

    $display("[TB] session with delayed pause_ack and random reads");
    open_session(5);
    mem[12'h012] = 8'h5A;
    applyStimulus(25'h012, 1'b0);
    checkOutput("first_read_checksum", checksum, 8'h5A);
    for (int i = 0; i < 20; i++) applyStimulus(rand_addr(), 1'($urandom_range(0, 1)));
    close_session();

    $display("[TB] out-of-window read and checksum wrap");
    open_session(1);
    mem[1] = 8'h02;
    applyStimulus(25'h400, 1'b0);
    applyStimulus(25'h001, 1'b0);
    checkOutput("wrap_checksum", checksum, 8'h01);
    close_session();

    $display("[TB] foreign index is ignored");
    ioctl_index  = 8'd0;
    ioctl_upload = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      ioctl_rd   = (i == 0);
      ioctl_addr = 25'h005;
      checkOutput("foreign_pause_req", pause_req, 0);
      checkOutput("foreign_wait", ioctl_wait, 0);
      checkOutput("foreign_busy", busy, 0);
      checkOutput("foreign_ram_rd", ram_rd, 0);
    end
    ioctl_upload = 1'b0;
    step();
    checkOutput("foreign_done", done, 0);
    checkOutput("foreign_checksum", checksum, exp_sum);

    $display("[TB] abort during fetch");
    open_session(2);
    for (int i = 0; i < 3; i++) applyStimulus(rand_addr(), 1'b0);
    ioctl_addr = 25'h020;
    ioctl_rd   = 1'b1;
    step();
    ioctl_rd = 1'b0;
    checkOutput("abort_ram_rd", ram_rd, 1);
    step();
    ioctl_upload = 1'b0;
    pause_ack    = 1'b0;
    step();
    checkOutput("abort_done", done, 1);
    checkOutput("abort_pause_req", pause_req, 0);
    checkOutput("abort_wait", ioctl_wait, 0);
    checkOutput("abort_checksum", checksum, exp_sum);
    repeat (2) step();
    checkOutput("abort_done_once", done, 0);
    checkOutput("abort_checksum_hold", checksum, exp_sum);
    checkOutput("abort_din_hold", ioctl_din, exp_din);
    open_session(3);
    applyStimulus(rand_addr(), 1'b0);
    close_session();

    $display("[TB] reset in the middle of a fetch");
    open_session(1);
    ioctl_addr = 25'h033;
    ioctl_rd   = 1'b1;
    step();
    ioctl_rd = 1'b0;
    reset_n  = 1'b0;
    #1;
    checkOutput("midrst_ram_rd", ram_rd, 0);
    checkOutput("midrst_wait", ioctl_wait, 0);
    checkOutput("midrst_pause_req", pause_req, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_din", ioctl_din, 0);
    checkOutput("midrst_checksum", checksum, 0);
    ioctl_upload = 1'b0;
    pause_ack    = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    repeat (2) step();
    checkOutput("post_rst_busy", busy, 0);
    checkOutput("post_rst_done", done, 0);
    open_session(2);
    for (int i = 0; i < 4; i++) applyStimulus(rand_addr(), 1'($urandom_range(0, 1)));
    close_session();

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
